// File: rtl/disp_block_scheduler.sv
// disp_block_scheduler
// Walks a grid of non-overlapping f-window origins across the image and starts
// one match run per origin. Candidate scores from the engine are reduced to
// the best (minimum score, lowest disparity on ties) and the winning disparity
// is written to the disparity-map RAM. Origins too close to the right edge to
// hold a full disparity search are skipped and written as INVALID (7'h7F).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   frame_start         one-cycle pulse, starts a frame pass (accepted in IDLE only)
//   busy                high from the first DISPATCH cycle to the DONE cycle
//   frame_done          one-cycle pulse after the last map write
//   win_x, win_y        current f-window origin, stable for the whole run
//   eng_start           one-cycle engine start pulse
//   res_valid/res_disp/res_score  serial candidate results from the engine
//   eng_done            end-of-run pulse from the engine
//   dmap_we/dmap_addr/dmap_data   disparity-map write port
//   err                 sticky engine timeout flag, cleared by frame_start
module disp_block_scheduler #(
  parameter int unsigned IMG_W   = 320,
  parameter int unsigned IMG_H   = 240,
  parameter int unsigned WIN     = 16,
  parameter int unsigned MAXD    = 64,
  parameter int unsigned SCORE_W = 16,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  output logic               busy,
  output logic               frame_done,
  output logic [8:0]         win_x,
  output logic [7:0]         win_y,
  output logic               eng_start,
  input  logic               res_valid,
  input  logic [5:0]         res_disp,
  input  logic [SCORE_W-1:0] res_score,
  input  logic               eng_done,
  output logic               dmap_we,
  output logic [ADDR_W-1:0]  dmap_addr,
  output logic [6:0]         dmap_data,
  output logic               err
);

  localparam int unsigned NBX  = IMG_W / WIN;
  localparam int unsigned NBY  = IMG_H / WIN;
  localparam int unsigned BX_W = (NBX > 1) ? $clog2(NBX) : 1;
  localparam int unsigned BY_W = (NBY > 1) ? $clog2(NBY) : 1;
  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [8:0]  COL_MAX = 9'(IMG_W - WIN - MAXD);
  localparam logic [6:0]  INVALID = 7'h7F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_WAIT,
    ST_WRITE,
    ST_SKIP,
    ST_NEXT,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [BX_W-1:0]    bx_q, bx_d;
  logic [BY_W-1:0]    by_q, by_d;
  logic [SCORE_W-1:0] best_score_q, best_score_d;
  logic [6:0]         best_disp_q, best_disp_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic [8:0]         win_x_d;
  logic [7:0]         win_y_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [6:0]         data_d;
  logic               err_d;
  logic               cand_better;
  logic               row_end;
  logic               last_block;

  // Candidate comparison: lower score wins, lower disparity breaks ties.
  always_comb begin
    cand_better = res_valid &&
                  ((res_score < best_score_q) ||
                   ((res_score == best_score_q) && ({1'b0, res_disp} < best_disp_q)));
    row_end     = (bx_q == BX_W'(NBX - 1));
    last_block  = row_end && (by_q == BY_W'(NBY - 1));
  end

  // Next-state and next-register values.
  always_comb begin
    state_d      = state_q;
    bx_d         = bx_q;
    by_d         = by_q;
    best_score_d = best_score_q;
    best_disp_d  = best_disp_q;
    wdog_d       = wdog_q;
    win_x_d      = win_x;
    win_y_d      = win_y;
    addr_d       = dmap_addr;
    data_d       = dmap_data;
    err_d        = err;

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d = ST_DISPATCH;
          bx_d    = '0;
          by_d    = '0;
          win_x_d = '0;
          win_y_d = '0;
          addr_d  = '0;
          err_d   = 1'b0;
        end
      end

      ST_DISPATCH: begin
        if (win_x <= COL_MAX) begin
          best_score_d = '1;
          best_disp_d  = INVALID;
          wdog_d       = '0;
          state_d      = ST_WAIT;
        end else begin
          data_d  = INVALID;
          state_d = ST_SKIP;
        end
      end

      ST_WAIT: begin
        if (cand_better) begin
          best_score_d = res_score;
          best_disp_d  = {1'b0, res_disp};
        end
        wdog_d = wdog_q + WD_W'(1);
        // A result arriving with eng_done is already folded into best_disp_d.
        if (eng_done) begin
          data_d  = best_disp_d;
          state_d = ST_WRITE;
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          err_d       = 1'b1;
          best_disp_d = INVALID;
          data_d      = INVALID;
          state_d     = ST_WRITE;
        end
      end

      ST_WRITE: state_d = ST_NEXT;

      ST_SKIP: state_d = ST_NEXT;

      ST_NEXT: begin
        addr_d = dmap_addr + ADDR_W'(1);
        if (row_end) begin
          bx_d    = '0;
          win_x_d = '0;
          by_d    = by_q + BY_W'(1);
          win_y_d = win_y + 8'(WIN);
        end else begin
          bx_d    = bx_q + BX_W'(1);
          win_x_d = win_x + 9'(WIN);
        end
        state_d = last_block ? ST_DONE : ST_DISPATCH;
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs; outputs reflect the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bx_q         <= '0;
      by_q         <= '0;
      best_score_q <= '1;
      best_disp_q  <= INVALID;
      wdog_q       <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      eng_start    <= 1'b0;
      dmap_we      <= 1'b0;
      dmap_addr    <= '0;
      dmap_data    <= INVALID;
      win_x        <= '0;
      win_y        <= '0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      bx_q         <= bx_d;
      by_q         <= by_d;
      best_score_q <= best_score_d;
      best_disp_q  <= best_disp_d;
      wdog_q       <= wdog_d;
      busy         <= (state_d != ST_IDLE);
      frame_done   <= (state_d == ST_DONE);
      eng_start    <= (state_d == ST_DISPATCH) && (win_x_d <= COL_MAX);
      dmap_we      <= (state_d == ST_WRITE) || (state_d == ST_SKIP);
      dmap_addr    <= addr_d;
      dmap_data    <= data_d;
      win_x        <= win_x_d;
      win_y        <= win_y_d;
      err          <= err_d;
    end
  end

endmodule
